// File: rtl/tag_lookup_ctrl_t0.sv
// tag_lookup_ctrl_t0: lookup/allocate controller for the way-0 tag RAM.
// Takes one {tag, index, offset} request at a time, reads the indexed entry,
// compares it, optionally allocates on a miss, and returns hit/evict status.
// Optional build macro TAG_FLUSH_EN adds a flush port that invalidates
// every entry, one write per cycle.
module tag_lookup_ctrl_t0 #(
    parameter int AWIDTH   = 3,
    parameter int DWIDTH   = 14,
    parameter int OFFSET_W = 2,
    localparam int TAG_W   = DWIDTH - 1,
    localparam int RA_W    = TAG_W + AWIDTH + OFFSET_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [RA_W-1:0]   req_addr,
    input  logic              req_alloc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic              resp_evict,
    output logic [TAG_W-1:0]  resp_victim,
    output logic [AWIDTH-1:0] tag_addr,
    output logic [DWIDTH-1:0] tag_din,
    output logic              tag_we,
    input  logic [DWIDTH-1:0] tag_dout
`ifdef TAG_FLUSH_EN
    ,
    input  logic              flush_req,
    output logic              flush_busy
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG_RD,
        S_CMP,
        S_ALLOC,
        S_RESP
`ifdef TAG_FLUSH_EN
        ,
        S_FLUSH
`endif
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [AWIDTH-1:0] idx;
        logic              alloc;
    } req_t;

    state_t state;
    req_t   req_q;

    logic [TAG_W-1:0]  in_tag;
    logic [AWIDTH-1:0] in_idx;
    logic              hit_c;
    logic              unused_offset;

    assign in_tag = req_addr[RA_W-1 -: TAG_W];
    assign in_idx = req_addr[OFFSET_W +: AWIDTH];
    // Offset bits select a byte within the line; lookup never needs them.
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    // Entry must be valid and carry the requested tag.
    assign hit_c = tag_dout[DWIDTH-1] && (tag_dout[TAG_W-1:0] == req_q.tag);

`ifdef TAG_FLUSH_EN
    logic [AWIDTH-1:0] fl_cnt;

    // Ready only in IDLE, and a pending flush steals the IDLE cycle.
    assign req_ready = (state == S_IDLE) && !flush_req;
`else
    // Ready only in IDLE.
    assign req_ready = (state == S_IDLE);
`endif

    // Main FSM; all RAM-side and response outputs are registered here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            req_q       <= '0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_evict  <= 1'b0;
            resp_victim <= '0;
            tag_addr    <= '0;
            tag_din     <= '0;
            tag_we      <= 1'b0;
`ifdef TAG_FLUSH_EN
            fl_cnt      <= '0;
            flush_busy  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
`ifdef TAG_FLUSH_EN
                    if (flush_req) begin
                        // First flush write lands on entry 0 next cycle.
                        fl_cnt     <= '0;
                        tag_addr   <= '0;
                        tag_din    <= '0;
                        tag_we     <= 1'b1;
                        flush_busy <= 1'b1;
                        state      <= S_FLUSH;
                    end else
`endif
                    if (req_valid) begin
                        req_q    <= '{tag: in_tag, idx: in_idx, alloc: req_alloc};
                        tag_addr <= in_idx;
                        tag_we   <= 1'b0;
                        state    <= S_TAG_RD;
                    end
                end
                // RAM latches tag_addr at the end of this cycle.
                S_TAG_RD: state <= S_CMP;
                S_CMP: begin
                    resp_hit <= hit_c;
                    if (!hit_c && req_q.alloc) begin
                        resp_evict  <= tag_dout[DWIDTH-1];
                        resp_victim <= tag_dout[TAG_W-1:0];
                        tag_din     <= {1'b1, req_q.tag};
                        tag_we      <= 1'b1;
                        state       <= S_ALLOC;
                    end else begin
                        resp_evict  <= 1'b0;
                        resp_victim <= '0;
                        resp_valid  <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                // Single-cycle write; tag_addr still holds the index.
                S_ALLOC: begin
                    tag_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
`ifdef TAG_FLUSH_EN
                S_FLUSH: begin
                    fl_cnt   <= fl_cnt + 1'b1;
                    tag_addr <= fl_cnt + 1'b1;
                    if (&fl_cnt) begin
                        tag_we     <= 1'b0;
                        flush_busy <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl_t0.sv
// Directed bench for tag_lookup_ctrl_t0 with a behavioural sync-read tag RAM.
module tb_tag_lookup_ctrl_t0;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_alloc;
    logic [17:0] req_addr;
    logic        resp_valid, resp_ready, resp_hit, resp_evict;
    logic [12:0] resp_victim;
    logic [2:0]  tag_addr;
    logic [13:0] tag_din, tag_dout;
    logic        tag_we;
`ifdef TAG_FLUSH_EN
    logic        flush_req, flush_busy;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    tag_lookup_ctrl_t0 dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_alloc(req_alloc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_evict(resp_evict), .resp_victim(resp_victim),
        .tag_addr(tag_addr), .tag_din(tag_din), .tag_we(tag_we), .tag_dout(tag_dout)
`ifdef TAG_FLUSH_EN
        , .flush_req(flush_req), .flush_busy(flush_busy)
`endif
    );

    always #5 clock = ~clock;

    // Sync-read tag RAM: dout = mem[address latched at last edge].
    logic [13:0] mem [8] = '{default: 14'h0};
    logic [2:0]  rd_addr = 3'd0;
    logic        bk_we = 1'b0;
    logic [2:0]  bk_addr = 3'd0;
    logic [13:0] bk_data = 14'h0;
    int          we_cycles = 0;
    logic [2:0]  w_addr = 3'd0;
    logic [13:0] w_din = 14'h0;

    always @(posedge clock) begin
        if (tag_we) begin
            mem[tag_addr] <= tag_din;
            we_cycles     <= we_cycles + 1;
            w_addr        <= tag_addr;
            w_din         <= tag_din;
        end else if (bk_we) begin
            mem[bk_addr] <= bk_data;
        end
        rd_addr <= tag_addr;
    end
    assign tag_dout = mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request and wait for resp_valid; lat = cycles after accept edge.
    task automatic send(input logic [17:0] a, input logic al, output int lat);
        @(negedge clock);
        req_valid = 1'b1; req_addr = a; req_alloc = al;
        chk("req_ready_idle", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk("resp_drop", resp_valid, 0);
        chk("ready_back", req_ready, 1);
    endtask

    task automatic backdoor(input logic [2:0] a, input logic [13:0] d);
        @(negedge clock);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(negedge clock);
        bk_we = 1'b0;
    endtask

    initial begin
        int lat, wc0, nb;
        logic h0, e0;
        logic [12:0] v0;
        resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_alloc = 1'b0; resp_ready = 1'b0;
`ifdef TAG_FLUSH_EN
        flush_req = 1'b0;
`endif
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_hit", resp_hit, 0);
        chk("rst_evict", resp_evict, 0);
        chk("rst_victim", resp_victim, 0);
        chk("rst_we", tag_we, 0);
        chk("rst_addr", tag_addr, 0);
        chk("rst_din", tag_din, 0);
`ifdef TAG_FLUSH_EN
        chk("rst_flush_busy", flush_busy, 0);
`endif
        @(negedge clock); resetn = 1'b1;

        // Lookup only on a zeroed RAM: miss, no write.
        wc0 = we_cycles;
        send(18'h00014, 1'b0, lat);
        chk("lk_lat", lat, 3);
        chk("lk_hit", resp_hit, 0);
        chk("lk_evict", resp_evict, 0);
        chk("lk_no_we", we_cycles - wc0, 0);
        ack();

        // Allocate on miss into an invalid entry.
        wc0 = we_cycles;
        send(18'h00014, 1'b1, lat);
        chk("al_lat", lat, 4);
        chk("al_hit", resp_hit, 0);
        chk("al_evict", resp_evict, 0);
        chk("al_we_cnt", we_cycles - wc0, 1);
        chk("al_waddr", w_addr, 5);
        chk("al_wdin", w_din, 14'h2000);
        ack();

        // Repeat lookup now hits.
        send(18'h00014, 1'b0, lat);
        chk("rp_lat", lat, 3);
        chk("rp_hit", resp_hit, 1);
        ack();

        // Evict a valid entry holding tag 0x0AA with tag 0x055.
        backdoor(3'd5, 14'h20AA);
        send(18'h00AB4, 1'b1, lat);
        chk("ev_lat", lat, 4);
        chk("ev_hit", resp_hit, 0);
        chk("ev_evict", resp_evict, 1);
        chk("ev_victim", resp_victim, 13'h0AA);
        ack();
        chk("ev_ram5", mem[5], 14'h2055);

        // Back-pressure: hold resp_ready low 5 cycles, pulse an ignored request.
        send(18'h00AB4, 1'b0, lat);
        h0 = resp_hit; e0 = resp_evict; v0 = resp_victim;
        chk("bp_hit", h0, 1);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 2); req_addr = 18'h00008; req_alloc = 1'b1;
            chk("bp_valid", resp_valid, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_fields", {resp_hit, resp_evict, resp_victim}, {h0, e0, v0});
            @(negedge clock);
        end
        req_valid = 1'b0;
        ack();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("bp_no_accept", {resp_valid, req_ready}, 2'b01);
        end

        // Back-to-back allocate to the same index: second sees the new tag.
        wc0 = we_cycles;
        send(18'h02228, 1'b1, lat);   // tag 0x111, idx 2
        chk("bb1_hit", resp_hit, 0);
        ack();
        send(18'h02228, 1'b1, lat);
        chk("bb2_lat", lat, 3);
        chk("bb2_hit", resp_hit, 1);
        chk("bb_we_cnt", we_cycles - wc0, 1);
        ack();

        // Reset asserted during ALLOC aborts the write.
        @(negedge clock);
        req_valid = 1'b1; req_addr = 18'h0246C; req_alloc = 1'b1;  // tag 0x123, idx 3
        @(negedge clock); req_valid = 1'b0;
        nb = 0;
        while (!tag_we && nb < 10) begin @(negedge clock); nb++; end
        chk("ra_in_alloc", tag_we, 1);
        resetn = 1'b0;
        #1;
        chk("ra_we", tag_we, 0);
        chk("ra_resp_valid", resp_valid, 0);
        chk("ra_outs", {resp_hit, resp_evict, resp_victim, tag_addr, tag_din}, 0);
        @(negedge clock); @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("ra_ready", req_ready, 1);
        chk("ra_ram3", mem[3], 14'h0);

`ifdef TAG_FLUSH_EN
        // Flush wins over a simultaneous request and clears every entry.
        @(negedge clock);
        flush_req = 1'b1; req_valid = 1'b1; req_addr = 18'h00014; req_alloc = 1'b0;
        #1;
        chk("fl_ready_low", req_ready, 0);
        wc0 = we_cycles;
        @(negedge clock);
        flush_req = 1'b0; req_valid = 1'b0;
        chk("fl_busy", flush_busy, 1);
        nb = 1;
        while (flush_busy && nb < 20) begin
            @(negedge clock);
            if (flush_busy) nb++;
        end
        chk("fl_cycles", nb, 8);
        chk("fl_writes", we_cycles - wc0, 8);
        chk("fl_no_resp", resp_valid, 0);
        begin
            logic [13:0] acc;
            acc = '0;
            for (int i = 0; i < 8; i++) acc |= mem[i];
            chk("fl_ram_zero", acc, 0);
        end
        send(18'h00AB4, 1'b0, lat);
        chk("fl_miss5", resp_hit, 0);
        ack();
        send(18'h02228, 1'b0, lat);
        chk("fl_miss2", resp_hit, 0);
        ack();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
